nibble_pair_packer: RTL

NIBBLE_PAIR_PACKER -- requirements
Module: nibble_pair_packer

---
 rtl/nibble_pkg.sv | 29 ++
 rtl/nibble_rr_arb2.sv | 47 ++++
 rtl/nibble_pair_packer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// nibble_pkg -- shared types for the nibble pair packer.
//   nibble_pair_t   : one 8-bit source record (two nibbles).
//   pair_of_pairs_t : two records packed into one 16-bit word;
//                     .first occupies the upper byte.
//   pk_state_e      : collection state of the packer.
//   pair_parity()   : even-parity helper over a packed pair.
package nibble_pkg;

    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
    } nibble_pair_t;

    typedef struct packed {
        nibble_pair_t first;
        nibble_pair_t second;
    } pair_of_pairs_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pk_state_e;

    function automatic logic pair_parity(input pair_of_pairs_t p);
        return ^p;
    endfunction

endpackage

// File: rtl/nibble_rr_arb2.sv
// nibble_rr_arb2 -- two-way round-robin arbiter.
//   clk, rst_n : clock and asynchronous active-low reset.
//   req[1:0]   : request per source (already masked by the caller).
//   advance    : a grant was taken this cycle; remember who won.
//   grant[1:0] : one-hot (or zero) grant, combinational from req.
// After reset source 0 wins a tie.
module nibble_rr_arb2
    import nibble_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Source that won the most recent accepted grant.
    logic last_q;
    logic last_d;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (advance) begin
            last_d = grant[1];
        end
    end

    // Reset value 1 means "source 1 went last", so source 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/nibble_pair_packer.sv
// nibble_pair_packer -- collects two 8-bit records from two round-robin
// arbitrated sources and presents them as one 16-bit pair.
//   clk, rst_n          : clock and asynchronous active-low reset.
//   in_valid[1:0]       : per-source record valid.
//   in_ready[1:0]       : per-source accept (at most one bit high).
//   in_data0, in_data1  : source records.
//   out_valid/out_ready : output handshake; out_valid is high exactly in FULL.
//   out_data            : .first = earlier record, .second = later record.
//   out_src             : bit1 = source of .first, bit0 = source of .second.
//   out_partial         : .second was zero-filled by timeout.
//   out_parity          : XOR of out_data, present only when the macro
//                         NIBBLE_PACKER_PARITY_EN is defined.
// Parameter TIMEOUT: cycles spent in HALF before a lone record is flushed
// with a zero second half (0 disables the flush).
module nibble_pair_packer
    import nibble_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     in_valid,
    output logic [1:0]     in_ready,
    input  nibble_pair_t   in_data0,
    input  nibble_pair_t   in_data1,
    output logic           out_valid,
    input  logic           out_ready,
    output pair_of_pairs_t out_data,
    output logic [1:0]     out_src,
    output logic           out_partial
`ifdef NIBBLE_PACKER_PARITY_EN
    ,
    output logic           out_parity
`endif
);

    // A zero TIMEOUT still gets a 1-bit timer so the declarations stay legal.
    localparam int              TMR_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
    localparam bit              FLUSH_EN = (TIMEOUT != 0);

    pk_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    pair_of_pairs_t out_data_q, out_data_d;
    logic [1:0]     out_src_q, out_src_d;
    logic           out_partial_q, out_partial_d;

    logic [1:0]     arb_req;
    logic [1:0]     arb_grant;
    logic           xfer;
    logic           xfer_src;
    nibble_pair_t   xfer_data;
    logic           timeout_hit;
    logic           pop;

    // Nothing is offered to the arbiter while a pair is waiting to leave.
    assign arb_req   = (state_q != FULL) ? in_valid : 2'b00;
    assign xfer      = |(in_valid & in_ready);
    assign xfer_src  = in_ready[1];
    assign xfer_data = in_ready[1] ? in_data1 : in_data0;
    assign pop       = (state_q == FULL) && out_ready;

    // A transfer in the same cycle always beats the flush.
    assign timeout_hit = FLUSH_EN && (state_q == HALF) && !xfer && (timer_q == TMR_LAST);

    nibble_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (xfer),
        .grant   (arb_grant)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (xfer) state_d = HALF;
            HALF:    if (xfer || timeout_hit) state_d = FULL;
            FULL:    if (pop) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output logic.
    always_comb begin
        in_ready  = arb_grant;
        out_valid = (state_q == FULL);
    end

    // Pair contents and HALF-state timer.
    always_comb begin
        out_data_d    = out_data_q;
        out_src_d     = out_src_q;
        out_partial_d = out_partial_q;
        timer_d       = timer_q;
        case (state_q)
            EMPTY: begin
                if (xfer) begin
                    out_data_d.first  = xfer_data;
                    out_data_d.second = '0;
                    out_src_d         = {xfer_src, 1'b0};
                    out_partial_d     = 1'b0;
                    timer_d           = '0;
                end
            end
            HALF: begin
                if (xfer) begin
                    out_data_d.second = xfer_data;
                    out_src_d[0]      = xfer_src;
                    out_partial_d     = 1'b0;
                end else begin
                    if (timeout_hit) begin
                        out_data_d.second = '0;
                        out_src_d[0]      = 1'b0;
                        out_partial_d     = 1'b1;
                    end
                    // Saturate rather than wrap.
                    if (timer_q != TMR_MAX) begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q    <= '0;
            out_src_q     <= 2'b00;
            out_partial_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            out_data_q    <= out_data_d;
            out_src_q     <= out_src_d;
            out_partial_q <= out_partial_d;
            timer_q       <= timer_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_src     = out_src_q;
    assign out_partial = out_partial_q;

`ifdef NIBBLE_PACKER_PARITY_EN
    logic out_parity_q;

    // Computed from the next data so parity and data update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity_q <= 1'b0;
        end else begin
            out_parity_q <= pair_parity(out_data_d);
        end
    end

    assign out_parity = out_parity_q;
`endif

endmodule
